// File: rtl/xcnt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xcnt_pkg
// Brief    : Shared encodings for the x_count_fsm event counter family.
// Revision : 1.0 - initial release
// ============================================================================
package xcnt_pkg;

    // End-of-range behaviour
    localparam int MODE_WRAP  = 0;
    localparam int MODE_SAT   = 1;

    // Event qualification
    localparam int EDGE_LEVEL = 0;
    localparam int EDGE_RISE  = 1;

    // Count direction as seen on the dir input
    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

endpackage : xcnt_pkg
`default_nettype wire

// File: rtl/xcnt_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : xcnt_edge_det
// Brief    : Holds the one-cycle delayed copy of x and produces the qualified
//            event. EDGE_LEVEL: every cycle with x high is an event.
//            EDGE_RISE: only a 0->1 transition of x is an event.
// Revision : 1.0 - initial release
// ============================================================================
module xcnt_edge_det
    import xcnt_pkg::*;
#(
    parameter int EDGE = EDGE_LEVEL
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic x,
    output logic ev
);

    // Delayed copy of x; samples every cycle regardless of en or clr so that
    // edges arriving while disabled are consumed rather than replayed later.
    logic x_d_q;
    logic x_d_d;

    // Next value of the delay register is simply the current x
    always_comb begin
        x_d_d = x;
    end

    // Delay register, cleared by reset so x high right after reset is an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_d_q <= 1'b0;
        end else begin
            x_d_q <= x_d_d;
        end
    end

    // Qualified event; the edge term collapses to 1 in level mode
    always_comb begin
        ev = en & x & ((EDGE == EDGE_RISE) ? ~x_d_q : 1'b1);
    end

endmodule : xcnt_edge_det
`default_nettype wire

// File: rtl/x_count_fsm.sv
`default_nettype none
// ============================================================================
// Module   : x_count_fsm
// Brief    : Parametrised Moore event counter. Steps through NUM_STATES
//            states on qualified x events (up or down, wrap or saturate) and
//            asserts y while in the terminal state NUM_STATES-1.
//            Optional macro XCNT_TERM_PULSE_EN adds a registered term_pulse
//            output flagging events that hit either end of the range.
// Revision : 1.0 - initial release
// ============================================================================
module x_count_fsm
    import xcnt_pkg::*;
#(
    parameter  int NUM_STATES = 4,
    parameter  int MODE       = MODE_WRAP,
    parameter  int EDGE       = EDGE_LEVEL,
    localparam int W          = $clog2(NUM_STATES)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic         x,
    input  logic         dir,
    output logic [W-1:0] state,
    output logic         y
`ifdef XCNT_TERM_PULSE_EN
    ,
    output logic         term_pulse
`endif
);

    // First and terminal state encodings
    localparam logic [W-1:0] S_ZERO = '0;
    localparam logic [W-1:0] S_TERM = W'(NUM_STATES - 1);

    logic         ev;
    logic         legal;
    logic [W-1:0] state_q;
    logic [W-1:0] state_d;
    logic         y_q;
    logic         y_d;

    xcnt_edge_det #(
        .EDGE (EDGE)
    ) u_edge_det (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .x   (x),
        .ev  (ev)
    );

    // Encodings at or above NUM_STATES are unreachable in normal operation
    always_comb begin
        legal = (int'(state_q) < NUM_STATES);
    end

    // Next state: clear beats event beats hold; stray encodings recover to 0
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = S_ZERO;
        end else if (!legal) begin
            state_d = S_ZERO;
        end else if (ev) begin
            if (dir == DIR_UP) begin
                if (state_q == S_TERM) begin
                    state_d = (MODE == MODE_SAT) ? S_TERM : S_ZERO;
                end else begin
                    state_d = state_q + 1'b1;
                end
            end else begin
                if (state_q == S_ZERO) begin
                    state_d = (MODE == MODE_SAT) ? S_ZERO : S_TERM;
                end else begin
                    state_d = state_q - 1'b1;
                end
            end
        end
        y_d = (state_d == S_TERM);
    end

    // State and terminal flag registered together so y always tracks state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_ZERO;
            y_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
        end
    end

    assign state = state_q;
    assign y     = y_q;

`ifdef XCNT_TERM_PULSE_EN
    logic term_pulse_q;
    logic term_pulse_d;

    // An event at an end of the range: wrap in MODE_WRAP, a dropped step in
    // MODE_SAT. Both cases share the same condition; clr suppresses it.
    always_comb begin
        term_pulse_d = ev & ~clr &
                       (((dir == DIR_UP)   && (state_q == S_TERM)) ||
                        ((dir == DIR_DOWN) && (state_q == S_ZERO)));
    end

    // One-cycle registered end-of-range flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            term_pulse_q <= 1'b0;
        end else begin
            term_pulse_q <= term_pulse_d;
        end
    end

    assign term_pulse = term_pulse_q;
`endif

endmodule : x_count_fsm
`default_nettype wire

// File: tb/tb_x_count_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_x_count_fsm
// Brief    : Self-checking bench for x_count_fsm. Three instances share the
//            stimulus: A = defaults, B = 5 states saturating, C = rising-edge.
//            Build with XCNT_TERM_PULSE_EN to also check term_pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_x_count_fsm;

`ifdef XCNT_TERM_PULSE_EN
    localparam logic [4:0] TP_MASK = 5'h1F;
`else
    localparam logic [4:0] TP_MASK = 5'h1E;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic clr = 1'b0;
    logic x   = 1'b0;
    logic dir = 1'b1;

    logic [1:0] st_a;
    logic [2:0] st_b;
    logic [1:0] st_c;
    logic       y_a, y_b, y_c;
`ifdef XCNT_TERM_PULSE_EN
    logic       tp_a, tp_b, tp_c;
`endif

    int checks = 0;
    int errors = 0;

    // Expected {state[2:0], y, term_pulse} per DUT, queued when driven
    typedef struct {
        int         dut;
        logic [4:0] v;
        string      tag;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    x_count_fsm u_a (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .x(x), .dir(dir),
        .state(st_a), .y(y_a)
`ifdef XCNT_TERM_PULSE_EN
        , .term_pulse(tp_a)
`endif
    );

    x_count_fsm #(.NUM_STATES(5), .MODE(1), .EDGE(0)) u_b (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .x(x), .dir(dir),
        .state(st_b), .y(y_b)
`ifdef XCNT_TERM_PULSE_EN
        , .term_pulse(tp_b)
`endif
    );

    x_count_fsm #(.NUM_STATES(4), .MODE(0), .EDGE(1)) u_c (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .x(x), .dir(dir),
        .state(st_c), .y(y_c)
`ifdef XCNT_TERM_PULSE_EN
        , .term_pulse(tp_c)
`endif
    );

    function automatic logic [4:0] obs(input int d);
        logic tp;
        tp = 1'b0;
        case (d)
            0: begin
`ifdef XCNT_TERM_PULSE_EN
                tp = tp_a;
`endif
                return {1'b0, st_a, y_a, tp};
            end
            1: begin
`ifdef XCNT_TERM_PULSE_EN
                tp = tp_b;
`endif
                return {st_b, y_b, tp};
            end
            default: begin
`ifdef XCNT_TERM_PULSE_EN
                tp = tp_c;
`endif
                return {1'b0, st_c, y_c, tp};
            end
        endcase
    endfunction

    task automatic drive(input logic e, input logic c, input logic xx, input logic d);
        en  = e;
        clr = c;
        x   = xx;
        dir = d;
    endtask

    // One active edge, then return on the falling edge for sampling/driving
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (obs(d) !== 5'b0) begin
                errors++;
                $display("FAIL reset dut%0d: got {st,y,tp}=%b expected 00000", d, obs(d));
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_wrap_up();
        exp_t e;
        logic [2:0] s;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b1);
            s = 3'((i + 1) % 4);
            sb.push_back('{0, {s, s == 3'd3, i == 3} & TP_MASK, "wrap_up"});
            cycle();
            e = sb.pop_front();
            checks++;
            if (obs(e.dut) !== e.v) begin
                errors++;
                $display("FAIL %s[%0d]: got {st,y,tp}=%b expected %b", e.tag, i, obs(e.dut), e.v);
            end
        end
    endtask

    task automatic test_saturate();
        exp_t e;
        logic [2:0] s;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (i < 7) begin
                drive(1'b1, 1'b0, 1'b1, 1'b1);
                s = (i < 4) ? 3'(i + 1) : 3'd4;
                sb.push_back('{1, {s, s == 3'd4, i >= 4} & TP_MASK, "saturate_up"});
            end else begin
                drive(1'b1, 1'b0, 1'b1, 1'b0);
                s = (i == 7) ? 3'd3 : 3'd2;
                sb.push_back('{1, {s, 1'b0, 1'b0} & TP_MASK, "saturate_down"});
            end
            cycle();
            e = sb.pop_front();
            checks++;
            if (obs(e.dut) !== e.v) begin
                errors++;
                $display("FAIL %s[%0d]: got {st,y,tp}=%b expected %b", e.tag, i, obs(e.dut), e.v);
            end
        end
    endtask

    task automatic test_edge();
        exp_t e;
        logic [7:0] xs;
        xs = 8'b1011_1111;   // bit i is x on cycle i: 6 high, 1 low, 1 high
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, xs[i], 1'b1);
            sb.push_back('{2, {(i < 7) ? 3'd1 : 3'd2, 1'b0, 1'b0} & TP_MASK, "edge_rise"});
            cycle();
            e = sb.pop_front();
            checks++;
            if (obs(e.dut) !== e.v) begin
                errors++;
                $display("FAIL %s[%0d]: got {st,y,tp}=%b expected %b", e.tag, i, obs(e.dut), e.v);
            end
        end
    endtask

    task automatic test_wrap_down();
        exp_t e;
        logic [3:0] stim [4];   // {en, clr, x, dir}
        logic [4:0] expv [4];   // {state, y, tp}
        stim = '{4'b1010, 4'b1000, 4'b1001, 4'b1011};
        expv = '{5'b011_1_1, 5'b011_1_0, 5'b011_1_0, 5'b000_0_1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(stim[i][3], stim[i][2], stim[i][1], stim[i][0]);
            sb.push_back('{0, expv[i] & TP_MASK, "wrap_down"});
            cycle();
            e = sb.pop_front();
            checks++;
            if (obs(e.dut) !== e.v) begin
                errors++;
                $display("FAIL %s[%0d]: got {st,y,tp}=%b expected %b", e.tag, i, obs(e.dut), e.v);
            end
        end
    endtask

    task automatic test_clr_en();
        exp_t e;
        logic [3:0] stim [11];
        logic [4:0] expv [11];
        stim = '{4'b1011, 4'b1011, 4'b1111, 4'b1011, 4'b1011,
                 4'b0011, 4'b0011, 4'b0011, 4'b1011, 4'b1111, 4'b1001};
        expv = '{5'b001_0_0, 5'b010_0_0, 5'b000_0_0, 5'b001_0_0, 5'b010_0_0,
                 5'b010_0_0, 5'b010_0_0, 5'b010_0_0, 5'b011_1_0, 5'b000_0_0,
                 5'b000_0_0};
        do_reset();
        for (int i = 0; i < 11; i++) begin
            drive(stim[i][3], stim[i][2], stim[i][1], stim[i][0]);
            sb.push_back('{0, expv[i] & TP_MASK, "clr_en"});
            cycle();
            e = sb.pop_front();
            checks++;
            if (obs(e.dut) !== e.v) begin
                errors++;
                $display("FAIL %s[%0d]: got {st,y,tp}=%b expected %b", e.tag, i, obs(e.dut), e.v);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        logic [2:0] s;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b1);
            if (i == 3) begin
                // Pulse reset between edges and sample before the next edge
                #2 rst = 1'b1;
                #1;
                checks++;
                if (obs(0) !== 5'b0) begin
                    errors++;
                    $display("FAIL async_reset: got {st,y,tp}=%b expected 00000", obs(0));
                end
                #1 rst = 1'b0;
            end
            s = (i < 3) ? 3'(i + 1) : 3'(i - 2);
            sb.push_back('{0, {s, s == 3'd3, 1'b0} & TP_MASK, "async_reset"});
            cycle();
            e = sb.pop_front();
            checks++;
            if (obs(e.dut) !== e.v) begin
                errors++;
                $display("FAIL %s[%0d]: got {st,y,tp}=%b expected %b", e.tag, i, obs(e.dut), e.v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_saturate();
        test_edge();
        test_wrap_down();
        test_clr_en();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_x_count_fsm
`default_nettype wire

// File: doc/x_count_fsm.md
# x_count_fsm

Parametrised Moore event-counting state machine: advances through `NUM_STATES` states on qualified `x` events and asserts `y` while in the terminal state. It generalises the fixed four-state x-counter with configurable depth, up/down direction, wrap or saturate mode, level or rising-edge qualification, enable and synchronous clear. It sits in the FSM library as the standard event counter / sequence detector for control paths.

## Interface
**Parameters**
- `NUM_STATES`, default 4: number of states, ≥2; state width `W = $clog2(NUM_STATES)`.
- `MODE`, default 0: 0 = wrap at the ends, 1 = saturate at the ends.
- `EDGE`, default 0: 0 = every cycle with `x` high is an event, 1 = only rising edges of `x` are events.

**Ports**
- `clk` — in, 1: clock, rising edge.
- `rst` — in, 1: reset `rst`, asynchronous, active-high.
- `en` — in, 1: event enable.
- `clr` — in, 1: synchronous clear to state 0.
- `x` — in, 1: event input.
- `dir` — in, 1: 1 = count up, 0 = count down.
- `state` — out, W: current state index.
- `y` — out, 1: high iff `state == NUM_STATES-1`.
- `term_pulse` — out, 1: present only with `XCNT_TERM_PULSE_EN` (see Configuration).

## Operation
- Reset values: `state = 0`, `y = 0`, internal `x_d = 0`, `term_pulse = 0`.
- Event: `ev = en & (EDGE ? (x & ~x_d) : x)`.
  - `x_d` samples `x` every cycle, independent of `en` and `clr`.
  - With `EDGE=1`, `x` high on the first cycle after reset counts as an edge.
- Priority per clock edge: `clr` > `ev` > hold.
- States are 0 to `NUM_STATES-1`. State `NUM_STATES-1` is the terminal state `T`.
- Up (`dir=1`), on `ev`:
  - `s < T` → `s+1`.
  - `s == T` → 0 if `MODE=0`; stays at T if `MODE=1`.
- Down (`dir=0`), on `ev`:
  - `s > 0` → `s-1`.
  - `s == 0` → T if `MODE=0`; stays at 0 if `MODE=1`.
- `y` is registered and updated on the same edge as `state`, so it always equals `(state == T)`.
- Non-power-of-two `NUM_STATES`: encodings ≥ `NUM_STATES` are unreachable. If one is ever reached, the next edge forces state 0.
- `dir` is sampled only on event edges. Changing it between events has no other effect.

## Timing
- Latency: event sampled at edge k → `state` and `y` valid after edge k (one-cycle Moore).
- `clr` and `ev` asserted together: result is 0; no wrap is reported.
- Reset asserted mid-count: outputs go to reset values immediately, without waiting for a clock. Counting resumes from state 0 on the first edge after release.
- `en=0`: state holds. With `EDGE=1`, edges that occur while `en=0` are lost. They are not replayed later.
- Up to one state step per cycle. With `EDGE=0`, `x` held high steps once every cycle.

## Configuration
- `XCNT_TERM_PULSE_EN` defined: adds output `term_pulse`, registered.
  - High for exactly one cycle after any edge where an event hits an end:
    - `MODE=0`: wrap T→0 (up) or 0→T (down).
    - `MODE=1`: event dropped at saturation.
  - Low on `clr` and during reset.
- Macro undefined: `term_pulse` port and its logic are absent. All other behaviour is identical.

## Structure
- Package `xcnt_pkg` holds:
  - `MODE_WRAP = 0`, `MODE_SAT = 1`.
  - `EDGE_LEVEL = 0`, `EDGE_RISE = 1`.
  - `DIR_DOWN = 0`, `DIR_UP = 1`.
- One sub-module, `xcnt_edge_det`: holds the `x_d` register and produces the qualified event. It is parametrised by `EDGE`.
- Next-state logic and output registers stay in `x_count_fsm`.

## Test plan
- Defaults, `en=1`, `dir=1`, `x=1` for 4 cycles from reset → `state` 1,2,3,0; `y` high only the cycle `state=3`. With macro: `term_pulse` high the cycle `state` returns to 0.
- `NUM_STATES=5`, `MODE=1`, `dir=1`, `x=1` for 7 cycles → `state` 1,2,3,4,4,4,4; `y=1` from the 4th cycle on. Then `dir=0`, 2 events → 3,2; `y=0`.
- `EDGE=1`, `x` held high 6 cycles, then low 1, then high 1 → exactly 2 increments (`state=2`).
- `MODE=0`, `dir=0` from reset, 1 event → `state=3`, `y=1`. With macro: `term_pulse=1` for one cycle.
- `clr` and `x` both high at `state=2` → `state=0`, `y=0`, no `term_pulse`. `en=0` with `x=1` for 3 cycles → `state` unchanged.
- `rst` pulsed between clock edges at `state=3` → `state=0` and `y=0` before the next edge; counting restarts correctly after release.
